// File: rtl/busdec_ctrl_pkg.sv
// busdec_ctrl_pkg: shared definitions for the registered bus chip-select
// decoder (bus widths, active-low select levels, controller state encoding).
// Optional feature macro: BUSDEC_TIMEOUT_EN (adds the TERR state).
package busdec_ctrl_pkg;

    // Active-low select/strobe levels inherited from the original header.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int unsigned BUS_ADDR_WIDTH = 30;
    localparam int unsigned BUS_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RESP   = 3'd2,
        ERR    = 3'd3
`ifdef BUSDEC_TIMEOUT_EN
        ,
        TERR   = 3'd4
`endif
    } busdec_state_e;

endpackage

// File: rtl/busdec_ctrl_if.sv
// busdec_ctrl_if: master-side and slave-side bus signals of busdec_ctrl.
//   m_as_/m_rw/m_addr/m_wr_data        : transaction request from the core
//   m_rd_data/m_rdy_/m_err             : completion returned to the core
//   s_cs_/s_as_/s_rw/s_addr/s_wr_data  : access driven to the slaves
//   s_rdy_/s_rd_data                   : per-slave ready and read data
// Modport slave is the controller's view; modport master is the view of the
// core plus the attached slaves.
interface busdec_ctrl_if #(
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_SLV   = 4,
    parameter int unsigned PAGE_BITS = 8
);
    logic                        m_as_;
    logic                        m_rw;
    logic [ADDR_W-1:0]           m_addr;
    logic [DATA_W-1:0]           m_wr_data;
    logic [DATA_W-1:0]           m_rd_data;
    logic                        m_rdy_;
    logic                        m_err;
    logic [NUM_SLV-1:0]          s_cs_;
    logic                        s_as_;
    logic                        s_rw;
    logic [PAGE_BITS-1:0]        s_addr;
    logic [DATA_W-1:0]           s_wr_data;
    logic [NUM_SLV-1:0]          s_rdy_;
    logic [NUM_SLV*DATA_W-1:0]   s_rd_data;

    modport slave (
        input  m_as_, m_rw, m_addr, m_wr_data, s_rdy_, s_rd_data,
        output m_rd_data, m_rdy_, m_err, s_cs_, s_as_, s_rw, s_addr, s_wr_data
    );

    modport master (
        output m_as_, m_rw, m_addr, m_wr_data, s_rdy_, s_rd_data,
        input  m_rd_data, m_rdy_, m_err, s_cs_, s_as_, s_rw, s_addr, s_wr_data
    );
endinterface

// File: rtl/busdec_ctrl_tmr.sv
// busdec_tmr: access timeout counter for busdec_ctrl.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return count to zero (has priority over en)
//   en       : advance count by one
//   expired  : count has reached TMO_CYC-1
module busdec_tmr #(
    parameter int unsigned TMO_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CW'(TMO_CYC - 1));
endmodule

// File: rtl/busdec_ctrl.sv
// busdec_ctrl: registered, handshaked bus chip-select decoder. Accepts one
// master transaction, selects slave addr[ADDR_W-1:PAGE_BITS], drives its
// active-low chip select until the slave's active-low ready, then returns
// read data with a one-cycle m_rdy_ pulse. Unmapped addresses (and, with
// BUSDEC_TIMEOUT_EN defined, slaves silent for TMO_CYC cycles) end in an
// m_err pulse alongside m_rdy_.
//   clk, rst : clock, synchronous active-high reset
//   bus      : busdec_ctrl_if.slave (master request/response, slave access)
module busdec_ctrl
    import busdec_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_W    = BUS_DATA_WIDTH,
    parameter int unsigned NUM_SLV   = 4,
    parameter int unsigned PAGE_BITS = 8,
    parameter int unsigned TMO_CYC   = 15
) (
    input  logic         clk,
    input  logic         rst,
    busdec_ctrl_if.slave bus
);
    localparam int unsigned IW = ADDR_W - PAGE_BITS;
    localparam int unsigned SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
        $error("busdec_ctrl: NUM_SLV out of range");
    end
    if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_tmo
        $error("busdec_ctrl: TMO_CYC out of range");
    end

    busdec_state_e        state_q, state_nx;
    logic [SW-1:0]        idx_q, idx_nx;
    logic [NUM_SLV-1:0]   cs_q, cs_nx;
    logic                 as_q, as_nx;
    logic                 rdy_q, rdy_nx;
    logic                 err_q, err_nx;
    logic [DATA_W-1:0]    rd_q, rd_nx;
    logic                 rw_q, rw_nx;
    logic [PAGE_BITS-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0]    wd_q, wd_nx;
    logic [IW-1:0]        page_idx;

    assign page_idx = bus.m_addr[ADDR_W-1:PAGE_BITS];

`ifdef BUSDEC_TIMEOUT_EN
    logic tmr_expired;

    busdec_tmr #(.TMO_CYC(TMO_CYC)) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != ACCESS),
        .en      (state_q == ACCESS),
        .expired (tmr_expired)
    );
`endif

    // Outputs are registered, so the next-state logic also computes the
    // output values that belong to the state being entered.
    always_comb begin
        state_nx = state_q;
        idx_nx   = idx_q;
        cs_nx    = {NUM_SLV{DISABLE_}};
        as_nx    = DISABLE_;
        rdy_nx   = DISABLE_;
        err_nx   = 1'b0;
        rd_nx    = rd_q;
        rw_nx    = rw_q;
        addr_nx  = addr_q;
        wd_nx    = wd_q;

        case (state_q)
            IDLE: begin
                if (bus.m_as_ == ENABLE_) begin
                    rw_nx   = bus.m_rw;
                    addr_nx = bus.m_addr[PAGE_BITS-1:0];
                    wd_nx   = bus.m_wr_data;
                    if (page_idx < IW'(NUM_SLV)) begin
                        idx_nx           = page_idx[SW-1:0];
                        state_nx         = ACCESS;
                        cs_nx[idx_nx]    = ENABLE_;
                        as_nx            = ENABLE_;
                    end else begin
                        state_nx = ERR;
                        rdy_nx   = ENABLE_;
                        err_nx   = 1'b1;
                        rd_nx    = '0;
                    end
                end
            end
            ACCESS: begin
                if (bus.s_rdy_[idx_q] == ENABLE_) begin
                    state_nx = RESP;
                    rdy_nx   = ENABLE_;
                    rd_nx    = rw_q ? bus.s_rd_data[int'(idx_q) * DATA_W +: DATA_W] : '0;
`ifdef BUSDEC_TIMEOUT_EN
                end else if (tmr_expired) begin
                    state_nx = TERR;
                    rdy_nx   = ENABLE_;
                    err_nx   = 1'b1;
                    rd_nx    = '0;
`endif
                end else begin
                    cs_nx[idx_q] = ENABLE_;
                    as_nx        = ENABLE_;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cs_q    <= {NUM_SLV{DISABLE_}};
            as_q    <= DISABLE_;
            rdy_q   <= DISABLE_;
            err_q   <= 1'b0;
            rd_q    <= '0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_nx;
            idx_q   <= idx_nx;
            cs_q    <= cs_nx;
            as_q    <= as_nx;
            rdy_q   <= rdy_nx;
            err_q   <= err_nx;
            rd_q    <= rd_nx;
            rw_q    <= rw_nx;
            addr_q  <= addr_nx;
            wd_q    <= wd_nx;
        end
    end

    assign bus.s_cs_     = cs_q;
    assign bus.s_as_     = as_q;
    assign bus.m_rdy_    = rdy_q;
    assign bus.m_err     = err_q;
    assign bus.m_rd_data = rd_q;
    assign bus.s_rw      = rw_q;
    assign bus.s_addr    = addr_q;
    assign bus.s_wr_data = wd_q;
endmodule

// File: tb/tb_busdec_ctrl.sv
// tb_busdec_ctrl: directed and randomized transactions against busdec_ctrl
// with a transaction-level reference model of select, latency and response.
module tb_busdec_ctrl;
    localparam int unsigned ADDR_W    = 30;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_SLV   = 4;
    localparam int unsigned PAGE_BITS = 8;
    localparam int unsigned TMO       = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    busdec_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV),
                     .PAGE_BITS(PAGE_BITS)) bus ();

    busdec_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV),
                  .PAGE_BITS(PAGE_BITS), .TMO_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;
    logic [31:0] rd_model = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " cs"},  32'(bus.s_cs_), 32'hF);
        check({tag, " as"},  32'(bus.s_as_), 32'h1);
        check({tag, " rdy"}, 32'(bus.m_rdy_), 32'h1);
        check({tag, " err"}, 32'(bus.m_err), 32'h0);
        check({tag, " rd"},  bus.m_rd_data, rd_model);
    endtask

    task automatic drive_noise();
        bus.m_rw      = 1'($urandom);
        bus.m_addr    = 30'($urandom);
        bus.m_wr_data = $urandom;
        bus.s_rdy_    = 4'($urandom);
        for (int k = 0; k < int'(NUM_SLV); k++) bus.s_rd_data[k*DATA_W +: DATA_W] = $urandom;
    endtask

    // One master transaction; the selected slave answers after w wait cycles.
    task automatic txn(input string tag, input logic [29:0] addr, input logic rw,
                       input logic [31:0] wd, input int unsigned w, input logic [31:0] rdata);
        int unsigned idx = 32'(addr >> PAGE_BITS);
        bit          mapped = (idx < NUM_SLV);
        bit          timed_out = 1'b0;
        int unsigned done_cyc;
        logic [3:0]  cs_exp = 4'hF;
        logic [31:0] rd_exp;

`ifdef BUSDEC_TIMEOUT_EN
        timed_out = mapped && (w >= TMO);
`endif
        if (!mapped)       done_cyc = 1;
        else if (timed_out) done_cyc = 1 + TMO;
        else               done_cyc = 2 + w;
        if (mapped) cs_exp[idx] = 1'b0;
        rd_exp = (!mapped || timed_out || !rw) ? 32'h0 : rdata;

        @(negedge clk);
        drive_noise();
        bus.m_as_     = 1'b0;
        bus.m_rw      = rw;
        bus.m_addr    = addr;
        bus.m_wr_data = wd;

        for (int unsigned c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            if (c < done_cyc) begin
                check({tag, " cs"},  32'(bus.s_cs_), 32'(cs_exp));
                check({tag, " as"},  32'(bus.s_as_), 32'h0);
                check({tag, " rdy"}, 32'(bus.m_rdy_), 32'h1);
                check({tag, " err"}, 32'(bus.m_err), 32'h0);
                check({tag, " rd"},  bus.m_rd_data, rd_model);
            end else if (c == done_cyc) begin
                check({tag, " done cs"},  32'(bus.s_cs_), 32'hF);
                check({tag, " done as"},  32'(bus.s_as_), 32'h1);
                check({tag, " done rdy"}, 32'(bus.m_rdy_), 32'h0);
                check({tag, " done err"}, 32'(bus.m_err), 32'(!mapped || timed_out));
                check({tag, " done rd"},  bus.m_rd_data, rd_exp);
                rd_model = rd_exp;
            end else begin
                check_idle_outputs({tag, " after"});
            end
            check({tag, " s_rw"},   32'(bus.s_rw), 32'(rw));
            check({tag, " s_addr"}, 32'(bus.s_addr), 32'(addr[7:0]));
            check({tag, " s_wd"},   bus.s_wr_data, wd);

            drive_noise();
            bus.m_as_ = (c < done_cyc) ? 1'($urandom) : 1'b1;
            if (mapped) begin
                bus.s_rdy_[idx] = (c - 1 >= w) ? 1'b0 : 1'b1;
                bus.s_rd_data[idx*DATA_W +: DATA_W] = rdata;
            end
        end
        bus.s_rdy_ = '1;
    endtask

    initial begin
        bus.m_as_     = 1'b1;
        bus.m_rw      = 1'b1;
        bus.m_addr    = '0;
        bus.m_wr_data = '0;
        bus.s_rdy_    = '1;
        bus.s_rd_data = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset s_rw",   32'(bus.s_rw), 32'h1);
        check("reset s_addr", 32'(bus.s_addr), 32'h0);
        check("reset s_wd",   bus.s_wr_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        txn("rd0wait", 30'h105, 1'b1, 32'h0, 0, 32'hDEADBEEF);
        txn("wr3wait", 30'h2FF, 1'b0, 32'h12345678, 3, 32'hCAFEF00D);
        txn("unmapped", 30'h400, 1'b1, 32'h0, 0, 32'h0);
        txn("hiaddr", 30'h3FFF_FF12, 1'b0, 32'h55AA55AA, 0, 32'h0);
`ifdef BUSDEC_TIMEOUT_EN
        txn("timeout", 30'h3A0, 1'b1, 32'h0, TMO + 4, 32'h11112222);
`else
        txn("longwait", 30'h3A0, 1'b1, 32'h0, TMO + 4, 32'h11112222);
`endif
        txn("lastcyc", 30'h310, 1'b1, 32'h0, TMO - 1, 32'hA5A5_0001);

        // Reset during the second access cycle aborts the transfer silently.
        @(negedge clk);
        bus.m_as_   = 1'b0;
        bus.m_rw    = 1'b1;
        bus.m_addr  = 30'h2AB;
        bus.s_rdy_  = '1;
        @(negedge clk);
        bus.m_as_ = 1'b1;
        check("abort cs1", 32'(bus.s_cs_), 32'hB);
        @(negedge clk);
        check("abort cs2", 32'(bus.s_cs_), 32'hB);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_model = '0;
        check_idle_outputs("abort rst");
        check("abort s_rw", 32'(bus.s_rw), 32'h1);
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("abort idle");
        end
        txn("postrst", 30'h007, 1'b1, 32'h0, 1, 32'h0BADC0DE);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            logic [29:0] a;
            if ($urandom_range(3) == 0) a = 30'($urandom);
            else a = {22'($urandom_range(0, NUM_SLV)), 8'($urandom)};
            txn("rand", a, 1'($urandom), $urandom, $urandom_range(0, TMO + 2), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/busdec_ctrl.md
Name: busdec_ctrl

Overview:
- Registered, handshaked successor to the combinational bus chip-select decoder.
- Takes one master bus transaction, selects one of NUM_SLV slaves from the upper address bits, drives the slave's active-low chip select, and waits for the slave's active-low ready.
- Returns read data and ready to the master.
- Flags unmapped addresses and (optionally) hung slaves with a bus-error pulse.
- Sits between the MIPS core bus master and the memory/IO slaves.

Parameters:
- ADDR_W, 30, bus address width (matches BUS_ADDR_WIDTH).
- DATA_W, 32, bus data width.
- NUM_SLV, 4, number of slaves (1..16).
- PAGE_BITS, 8, low address bits per slave page; slave index = addr[ADDR_W-1:PAGE_BITS].
- TMO_CYC, 15, wait cycles before timeout (1..255).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset.
- m_as_  in  1  master address strobe, active low, one-cycle pulse.
- m_rw  in  1  1 = read, 0 = write.
- m_addr  in  ADDR_W  master address.
- m_wr_data  in  DATA_W  write data.
- m_rd_data  out  DATA_W  read data, valid while m_rdy_ is low.
- m_rdy_  out  1  transaction-done strobe, active low.
- m_err  out  1  bus error, high together with m_rdy_.
- s_cs_  out  NUM_SLV  per-slave chip select, active low, one-hot-or-none.
- s_as_  out  1  slave address strobe, active low.
- s_rw  out  1  latched rw.
- s_addr  out  PAGE_BITS  latched in-page offset.
- s_wr_data  out  DATA_W  latched write data.
- s_rdy_  in  NUM_SLV  per-slave ready, active low.
- s_rd_data  in  NUM_SLV*DATA_W  slave read data; slave k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - s_cs_ = all ones; s_as_ = 1.
  - m_rdy_ = 1; m_err = 0; m_rd_data = 0.
  - s_rw = 1; s_addr = 0; s_wr_data = 0.
  - Timeout counter = 0.
- All outputs are registered.
- IDLE:
  - On m_as_ == 0, latch rw, address offset and write data.
  - If index < NUM_SLV: latch index, go ACCESS.
  - Otherwise go ERR; no chip select is ever driven.
- ACCESS:
  - s_cs_[idx] = 0 and s_as_ = 0 for the whole state; the counter increments each cycle.
  - If s_rdy_[idx] == 0: capture s_rd_data slice (reads only; writes load 0) into m_rd_data, go RESP.
  - If s_rdy_[idx] is high and the counter == TMO_CYC-1: go TERR (timeout).
  - s_rdy_ bits of unselected slaves are ignored.
  - Ready and timeout in the same cycle: ready wins.
- RESP: m_rdy_ = 0 for exactly one cycle, m_err = 0, s_cs_ all high; next state IDLE.
- ERR / TERR: m_rdy_ = 0 and m_err = 1 for one cycle, m_rd_data = 0; next state IDLE.
- m_as_ is ignored in every state except IDLE.
- The master must not issue a new strobe until it has seen m_rdy_.
- Latency:
  - Strobe sampled at edge N.
  - s_cs_ low during cycle N+1.
  - If the slave answers immediately, m_rdy_ is low during cycle N+2.
  - Unmapped address: m_rdy_ and m_err are low/high during cycle N+1.
  - Timeout: m_rdy_ during cycle N+1+TMO_CYC.
- rst high mid-transaction: return to IDLE and reset values on the next edge; no m_rdy_ is generated for the aborted transfer.
- m_rd_data holds its value after RESP until the next completion or reset.

Optional Feature:
- Macro: BUSDEC_TIMEOUT_EN.
- Defined: timeout counter and TERR path present, as specified above.
- Undefined: no counter, no TERR state; ACCESS waits indefinitely for s_rdy_. m_err is raised only for unmapped addresses.

Decomposition:
- Shared package/header (with define.h): Enable_/Disable_ values, BUS_ADDR_WIDTH, BUS_DATA_WIDTH, and state encodings IDLE/ACCESS/RESP/ERR/TERR as 3-bit localparams.
- One natural sub-module: busdec_tmr.
  - Clear/enable timeout counter, width $clog2(TMO_CYC+1).
  - Output: expired flag.
  - Instantiated only under BUSDEC_TIMEOUT_EN.

Test Plan:
- Read, zero-wait: m_addr=0x105, m_rw=1, slave1 holds s_rdy_[1]=0 with data 0xDEADBEEF -> s_cs_=4'b1101 and s_addr=0x05 during N+1; m_rdy_=0, m_rd_data=0xDEADBEEF, m_err=0 during N+2.
- Write, 3 wait states: m_addr=0x2FF, m_wr_data=0x12345678, slave2 ready after 3 cycles -> s_cs_=4'b1011 held 4 cycles, s_wr_data=0x12345678; single m_rdy_ pulse, m_rd_data=0.
- Unmapped: m_addr=0x400 -> s_cs_ stays 4'b1111; m_rdy_=0 and m_err=1 during N+1 only.
- Timeout (macro on, TMO_CYC=15): slave3 never ready -> s_cs_[3] low 15 cycles; m_err/m_rdy_ pulse during N+16; m_rd_data=0.
- Ready on the final timeout cycle -> normal RESP, m_err=0.
- rst asserted in the 2nd ACCESS cycle -> next cycle s_cs_=4'b1111, m_rdy_=1; a subsequent read to slave0 completes normally.
